// File: rtl/rv32i_pkg.sv
// rv32i_pkg: constants and types shared by the RV32I fetch-stage files.
//   XLEN              datapath width
//   INSTR_NOP         canonical NOP (addi x0, x0, 0) shown when nothing is valid
//   RESET_PC_DEFAULT  default first fetch address after reset
//   IMEM_AW_DEFAULT   default instruction ROM word-address width
//   fetch_state_t     derived fetch occupancy state, for debug visibility
//   fetch_dbg_t       debug bundle exported by the fetch stage
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int IMEM_AW_DEFAULT = 5;

    // EMPTY: nothing in flight; RUN: one ROM read in flight;
    // FULL: skid entry occupied (a ROM read is also in flight).
    typedef enum logic [1:0] {
        FETCH_EMPTY = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FULL  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        fetch_state_t    state;
        logic [XLEN-1:0] word_idx;  // ROM word currently addressed (zero-extended)
    } fetch_dbg_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 1-entry {pc, instr} holding register for the fetch stage.
//   clk, rst      clock and synchronous active-high reset
//   flush         discard the held entry (redirect)
//   load          capture {in_pc, in_instr} and mark the entry valid
//   keep          keep the current entry (stalled while full)
//   in_pc/instr   entry to capture
//   hold_v        entry valid
//   hold_pc/instr held entry
// Priority: rst > flush > load > keep; with none of them the entry is released.
module fetch_skid_buf
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic            keep,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            hold_v,
    output logic [XLEN-1:0] hold_pc,
    output logic [XLEN-1:0] hold_instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v     <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= INSTR_NOP;
        end else if (flush) begin
            hold_v <= 1'b0;
        end else if (load) begin
            hold_v     <= 1'b1;
            hold_pc    <= in_pc;
            hold_instr <= in_instr;
        end else if (!keep) begin
            hold_v <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_rv32i.sv
// pc_fetch_rv32i: RV32I fetch stage in front of a 1-cycle synchronous ROM.
//   clk, rst        clock and synchronous active-high reset
//   redirect_valid  taken branch/jump; redirect_pc is the byte target
//   stall           decode cannot accept if_* this cycle
//   imem_pc         ROM address (the fetch_pc register)
//   imem_instr      ROM data for the previous cycle's imem_pc
//   if_valid        if_pc/if_instr carry a real instruction
//   if_pc/if_instr  instruction to decode (NOP when not valid)
//   misalign_err    1-cycle pulse after a redirect with a misaligned target
//   dbg             derived occupancy state and addressed ROM word
// Valid/ready: an instruction moves to decode on a cycle where if_valid=1 and
// stall=0; while stall=1 with if_valid=1, if_pc/if_instr hold steady.
// A redirect in the same cycle discards whatever is presented.
module pc_fetch_rv32i
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_instr,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            misalign_err,
    output fetch_dbg_t      dbg
);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            req_v;

    logic            hold_v;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;

    logic            skid_load;
    logic            skid_keep;

    // The ROM is always enabled, so a stalled in-flight word must be parked
    // in the skid entry; afterwards fetch_pc is held at req_pc so the ROM
    // keeps re-reading the word behind the parked one.
    assign skid_keep = hold_v & stall;
    assign skid_load = !hold_v & req_v & stall;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .load       (skid_load),
        .keep       (skid_keep),
        .in_pc      (req_pc),
        .in_instr   (imem_instr),
        .hold_v     (hold_v),
        .hold_pc    (hold_pc),
        .hold_instr (hold_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            req_pc       <= RESET_PC;
            req_v        <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (redirect_valid) begin
                fetch_pc     <= {redirect_pc[XLEN-1:2], 2'b00};
                req_v        <= 1'b0;
                misalign_err <= |redirect_pc[1:0];
            end else if (skid_keep) begin
                // Full and stalled: nothing moves.
            end else if (skid_load) begin
                req_pc <= fetch_pc;
                req_v  <= 1'b1;
            end else begin
                req_pc   <= fetch_pc;
                req_v    <= 1'b1;
                fetch_pc <= fetch_pc + 32'd4;  // wraps modulo 2^32
            end
        end
    end

    assign imem_pc  = fetch_pc;
    assign if_valid = hold_v | req_v;

    always_comb begin
        if_pc    = req_pc;
        if_instr = INSTR_NOP;
        if (hold_v) begin
            if_pc    = hold_pc;
            if_instr = hold_instr;
        end else if (req_v) begin
            if_instr = imem_instr;
        end
    end

    always_comb begin
        dbg.word_idx = XLEN'(fetch_pc[IMEM_AW+1:2]);
        if (hold_v)     dbg.state = FETCH_FULL;
        else if (req_v) dbg.state = FETCH_RUN;
        else            dbg.state = FETCH_EMPTY;
    end

endmodule
